// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM whose pulse width follows a signed, double-buffered command.
// Optional deadband around centre is enabled by defining SERVO_PWM_DEADBAND_EN.
module servo_pwm_gen #(
  parameter int N          = 8,
  parameter int PERIOD_CYC = 1_000_000,
  parameter int CENTER_CYC = 75_000,
  parameter int STEP_CYC   = 195,
  parameter int DEADBAND   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [N-1:0] cmd,
  input  logic                cmd_valid,
  output logic                pwm_out,
  output logic                frame_start,
  output logic                cmd_ack
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam int MW = N + $clog2(STEP_CYC) + 1;
  localparam logic signed [N-1:0] CMD_MIN    = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] CMD_MIN_P1 = CMD_MIN + N'(1);

  logic signed [N-1:0] shadow_q, shadow_d;
  logic [CW-1:0]       width_q, width_d;
  logic [CW-1:0]       active_w_q, active_w_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                pending_q, pending_d;
  logic                strobe_q, strobe_d;
  logic                pwm_q, pwm_d;
  logic                fs_q, fs_d;
  logic                ack_q, ack_d;

  logic signed [N-1:0]  cmd_clamp_s;
  logic signed [N-1:0]  cmd_shadow_s;
  logic signed [MW-1:0] prod_s;
  logic signed [CW:0]   width_sum_s;

`ifdef SERVO_PWM_DEADBAND_EN
  logic [N-1:0] cmd_mag_s;

  // Symmetric clamp, then small commands around centre collapse to zero.
  always_comb begin
    cmd_clamp_s  = (cmd == CMD_MIN) ? CMD_MIN_P1 : cmd;
    cmd_mag_s    = cmd_clamp_s[N-1] ? (~cmd_clamp_s + N'(1)) : cmd_clamp_s;
    cmd_shadow_s = (cmd_mag_s <= N'(DEADBAND)) ? '0 : cmd_clamp_s;
  end
`else
  logic unused_deadband_s;
  assign unused_deadband_s = (DEADBAND != 0);

  // Symmetric clamp only; the most negative code would otherwise overreach.
  always_comb begin
    cmd_clamp_s  = (cmd == CMD_MIN) ? CMD_MIN_P1 : cmd;
    cmd_shadow_s = cmd_clamp_s;
  end
`endif

  // Width of the buffered command; legal parameters keep the sum in 1..PERIOD_CYC-1.
  always_comb begin
    prod_s      = MW'(shadow_q) * $signed(MW'(STEP_CYC));
    width_sum_s = $signed((CW+1)'(CENTER_CYC)) + (CW+1)'(prod_s);
  end

  // Frame sequencing, command hand-over and next-state for every register.
  always_comb begin
    cnt_d      = cnt_q;
    run_d      = run_q;
    active_w_d = active_w_q;
    pwm_d      = 1'b0;
    fs_d       = 1'b0;
    ack_d      = 1'b0;
    shadow_d   = cmd_valid ? cmd_shadow_s : shadow_q;
    strobe_d   = cmd_valid;
    width_d    = width_sum_s[CW-1:0];
    // A command counts as pending only once its width has been computed.
    pending_d  = pending_q | strobe_q;
    if (en) begin
      run_d = 1'b1;
      if (!run_q || (cnt_q == CW'(PERIOD_CYC - 1))) begin
        cnt_d      = '0;
        active_w_d = width_q;
        fs_d       = 1'b1;
        ack_d      = pending_q;
        pending_d  = strobe_q;
        pwm_d      = (width_q != '0);
      end else begin
        cnt_d = cnt_q + CW'(1);
        pwm_d = ((cnt_q + CW'(1)) < active_w_q);
      end
    end else begin
      cnt_d = '0;
      run_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q   <= '0;
      width_q    <= CW'(CENTER_CYC);
      active_w_q <= CW'(CENTER_CYC);
      cnt_q      <= '0;
      run_q      <= 1'b0;
      pending_q  <= 1'b0;
      strobe_q   <= 1'b0;
      pwm_q      <= 1'b0;
      fs_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      width_q    <= width_d;
      active_w_q <= active_w_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      pending_q  <= pending_d;
      strobe_q   <= strobe_d;
      pwm_q      <= pwm_d;
      fs_q       <= fs_d;
      ack_q      <= ack_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
  assign cmd_ack     = ack_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: expected frames are queued as commands are driven
// and checked (pulse width, cmd_ack) by a monitor when each frame starts.
module tb_servo_pwm_gen;

  typedef struct {
    int   w;
    logic ack;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              en;
  logic signed [7:0] cmd;
  logic              cmd_valid;
  logic              pwm_out;
  logic              frame_start;
  logic              cmd_ack;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0;
  exp_t exp_q[$];
  exp_t cur;
  logic measuring = 1'b0;
  int   hi_cnt = 0;

  servo_pwm_gen #(
    .N(8), .PERIOD_CYC(1000), .CENTER_CYC(150), .STEP_CYC(1), .DEADBAND(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cmd(cmd), .cmd_valid(cmd_valid),
    .pwm_out(pwm_out), .frame_start(frame_start), .cmd_ack(cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pop one expectation per frame, check ack and measure the high time.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      measuring = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (frame_start === 1'b1) begin
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL frame_unexpected: observed frame_start with queue size %0d, expected >0", exp_q.size());
        end
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          tests++;
          assert (cmd_ack === cur.ack) else begin
            fails++;
            $error("FAIL frame_ack: observed %b expected %b", cmd_ack, cur.ack);
          end
          measuring = 1'b1;
          hi_cnt    = 0;
        end
      end else begin
        tests++;
        assert (cmd_ack === 1'b0) else begin
          fails++;
          $error("FAIL stray_ack: observed %b expected 0", cmd_ack);
        end
      end
      if (measuring) begin
        if (pwm_out === 1'b1) begin
          hi_cnt++;
        end else begin
          tests++;
          assert (hi_cnt === cur.w) else begin
            fails++;
            $error("FAIL pulse_width: observed %0d expected %0d", hi_cnt, cur.w);
          end
          measuring = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int w, input logic ack);
    exp_t e;
    e.w   = w;
    e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic signed [7:0] v);
    cmd       = v;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 2000);
    check(tag, int'(frame_start), 1);
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;
    #2 reset = 1'b0;
    skip(3);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_fs", int'(frame_start), 0);
    check("reset_ack", int'(cmd_ack), 0);

    // Idle frames at centre width, 1000-cycle period.
    push(150, 1'b0);
    push(150, 1'b0);
    en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    wait_fs("fs_A");
    t0 = cyc;
    wait_fs("fs_B");
    check("period", cyc - t0, 1000);

    // Full-scale positive, then most-negative code (clamped).
    skip(500);
    push(277, 1'b1);
    strobe(8'sd127);
    wait_fs("fs_C");
    skip(500);
    push(23, 1'b1);
    strobe(-8'sd128);
    wait_fs("fs_D");

    // Strobe on the load edge lands one frame later.
    push(23, 1'b0);
    push(160, 1'b1);
    skip(999);
    strobe(8'sd10);
    check("fs_E_on_load_edge", int'(frame_start), 1);
    wait_fs("fs_F");

    // Last of several strobes in a frame wins, acknowledged once.
    skip(100);
    strobe(8'sd5);
    skip(100);
    strobe(-8'sd20);
    skip(100);
    strobe(8'sd40);
    push(190, 1'b1);
    push(190, 1'b0);
    wait_fs("fs_G");
    wait_fs("fs_H");

    // Back to centre, then cut the pulse after 50 cycles with en.
    skip(300);
    strobe(8'sd0);
    push(50, 1'b1);
    wait_fs("fs_I");
    skip(49);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_pwm", int'(pwm_out), 0);
    skip(20);
    check("disabled_fs", int'(frame_start), 0);
    push(150, 1'b0);
    en = 1'b1;
    @(negedge clk);
    check("en_rise_fs", int'(frame_start), 1);
    check("en_rise_pwm", int'(pwm_out), 1);

    // Asynchronous reset mid-pulse.
    skip(20);
    reset = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_fs", int'(frame_start), 0);
    en = 1'b0;
    skip(5);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_reset_idle_pwm", int'(pwm_out), 0);
    end
    push(150, 1'b0);
    en = 1'b1;
    wait_fs("fs_K");

    // Small commands around centre.
    skip(200);
`ifdef SERVO_PWM_DEADBAND_EN
    push(150, 1'b1);
`else
    push(152, 1'b1);
`endif
    strobe(8'sd2);
    wait_fs("fs_L");
    skip(200);
    push(153, 1'b1);
    strobe(8'sd3);
    wait_fs("fs_M");
    skip(200);
`ifdef SERVO_PWM_DEADBAND_EN
    push(150, 1'b1);
`else
    push(148, 1'b1);
`endif
    strobe(-8'sd2);
    wait_fs("fs_N");
    skip(300);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
